// File: rtl/scmi_mbox_pkg.sv
// Shared definitions for the SCMI shared-memory mailbox: register offsets,
// status codes and the initiator FSM states.
package scmi_mbox_pkg;

  localparam logic [31:0] OffChanStatus = 32'h04;
  localparam logic [31:0] OffChanFlags  = 32'h10;
  localparam logic [31:0] OffLength     = 32'h14;
  localparam logic [31:0] OffHeader     = 32'h18;
  localparam logic [31:0] OffPayload    = 32'h1C;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_CHAN_ERR = 2'd1,
    ST_BUS_ERR  = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_e;

  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_WR_FLAGS, S_WR_LEN, S_WR_HDR, S_WR_PAY, S_WR_STAT,
    S_RING, S_WAIT, S_RD_STAT, S_RD_LEN, S_RD_HDR, S_RD_PAY, S_RESP
  } state_e;

  // Byte offset of payload word k.
  function automatic logic [31:0] pay_off(input logic [31:0] k);
    return OffPayload + (k << 2);
  endfunction

endpackage

// File: rtl/scmi_mbox_initiator_if.sv
// Register-bus link between the mailbox initiator (master) and the mailbox
// register block or bridge (slave); 32-bit data.
interface scmi_mbox_initiator_if #(
  parameter int unsigned AddrWidth = 64
) ();
  logic                 valid;
  logic [AddrWidth-1:0] addr;
  logic                 write;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 ready;
  logic [31:0]          rdata;
  logic                 error;

  modport master (output valid, addr, write, wdata, wstrb,
                  input  ready, rdata, error);
  modport slave  (input  valid, addr, write, wdata, wstrb,
                  output ready, rdata, error);
endinterface

// File: rtl/scmi_mbox_initiator.sv
// SCMI shared-memory mailbox initiator: posts one command into the mailbox,
// rings the doorbell, waits for completion and returns the response.
module scmi_mbox_initiator
  import scmi_mbox_pkg::*;
#(
  parameter int unsigned          AddrWidth       = 64,
  parameter logic [AddrWidth-1:0] BaseAddr        = '0,
  parameter int unsigned          MaxPayloadWords = 8,
  parameter logic [31:0]          DoorbellOffset  = 32'h3C,
  parameter int unsigned          TimeoutCycles   = 100000,
  localparam int unsigned         LW              = $clog2(MaxPayloadWords + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [31:0]                  cmd_hdr_i,
  input  logic [LW-1:0]                cmd_len_i,
  input  logic [32*MaxPayloadWords-1:0] cmd_payload_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [31:0]                  rsp_hdr_o,
  output logic [LW-1:0]                rsp_len_o,
  output logic [32*MaxPayloadWords-1:0] rsp_payload_o,
  output logic [1:0]                   rsp_status_o,
  scmi_mbox_initiator_if.master        reg_bus,
  input  logic                         completion_irq_i,
  output logic                         busy_o
);

  localparam int unsigned IW = (MaxPayloadWords > 1) ? $clog2(MaxPayloadWords) : 1;
  localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

  typedef logic [MaxPayloadWords-1:0][31:0] words_t;

  state_e               state_q, state_d;
  logic                 req_valid_q, req_valid_d;
  logic [AddrWidth-1:0] req_addr_q, req_addr_d;
  logic                 req_write_q, req_write_d;
  logic [31:0]          req_wdata_q, req_wdata_d;
  logic [LW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 comp_q, comp_d;
  logic [31:0]          hdr_q, hdr_d;
  logic [LW-1:0]        len_q, len_d;
  words_t               pay_q, pay_d;
  logic [31:0]          rsp_hdr_q, rsp_hdr_d;
  logic [LW-1:0]        rsp_len_q, rsp_len_d;
  words_t               rsp_pay_q, rsp_pay_d;
  status_e              status_q, status_d;
  logic                 rsp_valid_q, cmd_ready_q, busy_q;

  logic xfer_ok_c, xfer_err_c, tmo_exp_c;
  logic [31:0] n_words;

  assign xfer_ok_c  = req_valid_q && reg_bus.ready && !reg_bus.error;
  assign xfer_err_c = req_valid_q && reg_bus.ready && reg_bus.error;
  assign tmo_exp_c  = (TimeoutCycles != 0) && (tmo_q >= TW'(TimeoutCycles - 1));

  function automatic logic [AddrWidth-1:0] mbox_addr(input logic [31:0] off);
    return BaseAddr + AddrWidth'(off);
  endfunction

  // Next-state, request issue and capture logic; a new request is issued in the
  // same cycle the previous one completes so transfers can run back to back.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_write_d = req_write_q;
    req_wdata_d = req_wdata_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    comp_d      = comp_q;
    hdr_d       = hdr_q;
    len_d       = len_q;
    pay_d       = pay_q;
    rsp_hdr_d   = rsp_hdr_q;
    rsp_len_d   = rsp_len_q;
    rsp_pay_d   = rsp_pay_q;
    status_d    = status_q;
    n_words     = '0;

    case (state_q)
      S_IDLE: if (cmd_valid_i && cmd_ready_q) begin
        hdr_d       = cmd_hdr_i;
        len_d       = (cmd_len_i > LW'(MaxPayloadWords)) ? LW'(MaxPayloadWords) : cmd_len_i;
        pay_d       = words_t'(cmd_payload_i);
        rsp_hdr_d   = '0;
        rsp_len_d   = '0;
        rsp_pay_d   = '0;
        status_d    = ST_OK;
        tmo_d       = '0;
        state_d     = S_POLL;
        req_valid_d = 1'b1;
        req_write_d = 1'b0;
        req_addr_d  = mbox_addr(OffChanStatus);
        req_wdata_d = '0;
      end
      S_POLL: begin
        if (!tmo_exp_c) tmo_d = tmo_q + TW'(1);
        if (xfer_ok_c) begin
          if (reg_bus.rdata[0]) begin
            state_d     = S_WR_FLAGS;
            req_write_d = 1'b1;
            req_addr_d  = mbox_addr(OffChanFlags);
            req_wdata_d = 32'h1;
          end else if (tmo_exp_c) begin
            status_d    = ST_TIMEOUT;
            req_valid_d = 1'b0;
            state_d     = S_RESP;
          end
        end
      end
      S_WR_FLAGS: if (xfer_ok_c) begin
        state_d     = S_WR_LEN;
        req_addr_d  = mbox_addr(OffLength);
        req_wdata_d = 32'd4 + (32'(len_q) << 2);
      end
      S_WR_LEN: if (xfer_ok_c) begin
        state_d     = S_WR_HDR;
        req_addr_d  = mbox_addr(OffHeader);
        req_wdata_d = hdr_q;
      end
      S_WR_HDR: if (xfer_ok_c) begin
        if (len_q == '0) begin
          state_d     = S_WR_STAT;
          req_addr_d  = mbox_addr(OffChanStatus);
          req_wdata_d = '0;
        end else begin
          state_d     = S_WR_PAY;
          idx_d       = '0;
          req_addr_d  = mbox_addr(pay_off(32'd0));
          req_wdata_d = pay_q[0];
        end
      end
      S_WR_PAY: if (xfer_ok_c) begin
        if (idx_q == len_q - LW'(1)) begin
          state_d     = S_WR_STAT;
          req_addr_d  = mbox_addr(OffChanStatus);
          req_wdata_d = '0;
        end else begin
          idx_d       = idx_q + LW'(1);
          req_addr_d  = mbox_addr(pay_off(32'(idx_q) + 32'd1));
          req_wdata_d = pay_q[IW'(idx_q + LW'(1))];
        end
      end
      S_WR_STAT: if (xfer_ok_c) begin
        state_d     = S_RING;
        req_addr_d  = mbox_addr(DoorbellOffset);
        req_wdata_d = 32'h1;
      end
      S_RING: if (xfer_ok_c) begin
        state_d     = S_WAIT;
        req_valid_d = 1'b0;
        tmo_d       = '0;
      end
      S_WAIT: begin
        if (comp_q || completion_irq_i) begin
          state_d     = S_RD_STAT;
          req_valid_d = 1'b1;
          req_write_d = 1'b0;
          req_addr_d  = mbox_addr(OffChanStatus);
          req_wdata_d = '0;
        end else if (tmo_exp_c) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RD_STAT: if (xfer_ok_c) begin
        if (reg_bus.rdata[1]) status_d = ST_CHAN_ERR;
        state_d    = S_RD_LEN;
        req_addr_d = mbox_addr(OffLength);
      end
      S_RD_LEN: if (xfer_ok_c) begin
        if (reg_bus.rdata < 32'd4) begin
          status_d    = ST_CHAN_ERR;
          rsp_len_d   = '0;
          req_valid_d = 1'b0;
          state_d     = S_RESP;
        end else begin
          n_words = (reg_bus.rdata - 32'd1) >> 2;
          if (n_words > 32'(MaxPayloadWords)) n_words = 32'(MaxPayloadWords);
          rsp_len_d  = LW'(n_words);
          state_d    = S_RD_HDR;
          req_addr_d = mbox_addr(OffHeader);
        end
      end
      S_RD_HDR: if (xfer_ok_c) begin
        rsp_hdr_d = reg_bus.rdata;
        if (rsp_len_q == '0) begin
          req_valid_d = 1'b0;
          state_d     = S_RESP;
        end else begin
          idx_d      = '0;
          state_d    = S_RD_PAY;
          req_addr_d = mbox_addr(pay_off(32'd0));
        end
      end
      S_RD_PAY: if (xfer_ok_c) begin
        rsp_pay_d[IW'(idx_q)] = reg_bus.rdata;
        if (idx_q == rsp_len_q - LW'(1)) begin
          req_valid_d = 1'b0;
          state_d     = S_RESP;
        end else begin
          idx_d      = idx_q + LW'(1);
          req_addr_d = mbox_addr(pay_off(32'(idx_q) + 32'd1));
        end
      end
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (xfer_err_c) begin
      status_d    = ST_BUS_ERR;
      req_valid_d = 1'b0;
      state_d     = S_RESP;
    end

    // Completion is only armed from the doorbell onwards.
    if (state_d == S_RING && state_q != S_RING) comp_d = 1'b0;
    else if ((state_q == S_RING || state_q == S_WAIT) && completion_irq_i) comp_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      comp_q      <= 1'b0;
      hdr_q       <= '0;
      len_q       <= '0;
      pay_q       <= '0;
      rsp_hdr_q   <= '0;
      rsp_len_q   <= '0;
      rsp_pay_q   <= '0;
      status_q    <= ST_OK;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_write_q <= req_write_d;
      req_wdata_q <= req_wdata_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      comp_q      <= comp_d;
      hdr_q       <= hdr_d;
      len_q       <= len_d;
      pay_q       <= pay_d;
      rsp_hdr_q   <= rsp_hdr_d;
      rsp_len_q   <= rsp_len_d;
      rsp_pay_q   <= rsp_pay_d;
      status_q    <= status_d;
      rsp_valid_q <= (state_d == S_RESP);
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign reg_bus.valid = req_valid_q;
  assign reg_bus.addr  = req_addr_q;
  assign reg_bus.write = req_write_q;
  assign reg_bus.wdata = req_wdata_q;
  assign reg_bus.wstrb = 4'hF;

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_hdr_o     = rsp_hdr_q;
  assign rsp_len_o     = rsp_len_q;
  assign rsp_payload_o = rsp_pay_q;
  assign rsp_status_o  = status_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_scmi_mbox_initiator.sv
// Directed bench for scmi_mbox_initiator with a single-cycle mailbox
// memory responder and scripted completion/error behaviour.
module tb_scmi_mbox_initiator;
  import scmi_mbox_pkg::*;

  localparam int unsigned MPW  = 8;
  localparam int unsigned LW   = 4;
  localparam int unsigned TMO  = 50;
  localparam logic [63:0] BASE = 64'h0000_0000_4000_1000;
  localparam logic [31:0] DB   = 32'h3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_hdr = '0;
  logic [LW-1:0]    cmd_len = '0;
  logic [32*MPW-1:0] cmd_payload = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_hdr;
  logic [LW-1:0]    rsp_len;
  logic [32*MPW-1:0] rsp_payload;
  logic [1:0]       rsp_status;
  logic             irq;
  logic             busy;

  scmi_mbox_initiator_if #(.AddrWidth(64)) bus ();

  scmi_mbox_initiator #(
    .AddrWidth(64), .BaseAddr(BASE), .MaxPayloadWords(MPW),
    .DoorbellOffset(DB), .TimeoutCycles(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_hdr_i(cmd_hdr), .cmd_len_i(cmd_len), .cmd_payload_i(cmd_payload),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_hdr_o(rsp_hdr), .rsp_len_o(rsp_len), .rsp_payload_o(rsp_payload),
    .rsp_status_o(rsp_status),
    .reg_bus(bus),
    .completion_irq_i(irq), .busy_o(busy)
  );

  // Responder configuration, driven only by the stimulus block.
  logic        clr_log = 1'b0;
  int          busy_cfg = 0;
  int          irq_mode = 1;
  logic        err_en = 1'b0;
  logic [31:0] err_off = '0;
  logic        ch_err = 1'b0;
  logic [31:0] rsp_l_cfg = '0;
  logic [31:0] rsp_hdr_cfg = '0;
  logic [31:0] rsp_pay_cfg [0:7];

  // Responder state and logs.
  logic [31:0] mem [0:63];
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, db_cnt = 0, stat_pre = 0, rd_after_db = 0;
  int pay_rd = 0, busy_left = 0, irq_dly = 0, db_cyc = 0;
  logic [31:0] len_wr = '0, hdr_wr = '0, pay_wr0 = '0, db_val = '0;
  logic irq_q = 1'b0;

  logic [31:0] off;
  logic [5:0]  widx;
  logic        bus_err_c;
  assign off       = 32'(bus.addr - BASE);
  assign widx      = off[7:2];
  assign bus_err_c = err_en && bus.valid && (off == err_off);
  assign bus.ready = bus.valid;
  assign bus.error = bus_err_c;
  assign bus.rdata = (off == 32'h4 && busy_left != 0) ? 32'h0 : mem[widx];
  assign irq = irq_q || (irq_mode == 2 && bus.valid && bus.write && off == DB);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_log) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[1] <= 32'h1;
      wr_cnt <= 0; rd_cnt <= 0; db_cnt <= 0; stat_pre <= 0; rd_after_db <= 0;
      pay_rd <= 0; busy_left <= busy_cfg; irq_dly <= 0; irq_q <= 1'b0;
      len_wr <= '0; hdr_wr <= '0; pay_wr0 <= '0; db_val <= '0;
    end else begin
      irq_q <= (irq_dly == 1);
      if (irq_dly != 0) irq_dly <= irq_dly - 1;
      if (bus.valid && bus.ready && !bus_err_c) begin
        if (bus.write) begin
          wr_cnt <= wr_cnt + 1;
          if (off == 32'h14) len_wr <= bus.wdata;
          if (off == 32'h18) hdr_wr <= bus.wdata;
          if (off == 32'h1C) pay_wr0 <= bus.wdata;
          if (off == DB) begin
            db_cnt <= db_cnt + 1;
            db_val <= bus.wdata;
            db_cyc <= cyc;
            mem[1] <= {30'b0, ch_err, 1'b1};
            mem[5] <= rsp_l_cfg;
            mem[6] <= rsp_hdr_cfg;
            for (int k = 0; k < 8; k++) mem[7+k] <= rsp_pay_cfg[k];
            if (irq_mode == 1) irq_dly <= 3;
          end else begin
            mem[widx] <= bus.wdata;
          end
        end else begin
          rd_cnt <= rd_cnt + 1;
          if (wr_cnt == 0 && off == 32'h4) stat_pre <= stat_pre + 1;
          if (db_cnt > 0) rd_after_db <= rd_after_db + 1;
          if (db_cnt > 0 && off >= 32'h1C) pay_rd <= pay_rd + 1;
          if (off == 32'h4 && busy_left > 0) busy_left <= busy_left - 1;
        end
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk); clr_log = 1'b1;
    @(negedge clk); clr_log = 1'b0;
  endtask

  task automatic send(input logic [31:0] h, input logic [LW-1:0] l, input logic [32*MPW-1:0] p);
    int t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    chk("cmd_ready_before_send", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_hdr = h; cmd_len = l; cmd_payload = p;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag);
    int t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 300) begin @(negedge clk); t++; end
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
  endtask

  task automatic ack();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  initial begin
    logic [32*MPW-1:0] p;
    int rsp_cyc;
    logic found;
    for (int k = 0; k < 8; k++) rsp_pay_cfg[k] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_cmd_ready_after", 64'(cmd_ready), 64'd1);
    chk("rst_reg_valid", 64'(bus.valid), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_status", 64'(rsp_status), 64'd0);
    chk("rst_rsp_hdr", 64'(rsp_hdr), 64'd0);

    // Basic command, 2-word payload each way
    rsp_l_cfg = 32'd12; rsp_hdr_cfg = 32'h0001_0010; irq_mode = 1;
    rsp_pay_cfg[0] = 32'h0; rsp_pay_cfg[1] = 32'h7;
    for (int k = 2; k < 8; k++) rsp_pay_cfg[k] = 32'hC0DE_0000 + 32'(k);
    clear_log();
    p = '0; p[31:0] = 32'hA5; p[63:32] = 32'h5A;
    send(32'h0001_0010, 4'd2, p);
    chk("t1_first_req_valid", 64'(bus.valid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    get_rsp("t1");
    chk("t1_len_wr", 64'(len_wr), 64'd12);
    chk("t1_hdr_wr", 64'(hdr_wr), 64'h0001_0010);
    chk("t1_pay_wr0", 64'(pay_wr0), 64'hA5);
    chk("t1_db_val", 64'(db_val), 64'd1);
    chk("t1_db_cnt", 64'(db_cnt), 64'd1);
    chk("t1_wr_cnt", 64'(wr_cnt), 64'd7);
    chk("t1_rd_cnt", 64'(rd_cnt), 64'd6);
    chk("t1_status", 64'(rsp_status), 64'd0);
    chk("t1_rsp_len", 64'(rsp_len), 64'd2);
    chk("t1_rsp_hdr", 64'(rsp_hdr), 64'h0001_0010);
    chk("t1_pay_lo", rsp_payload[63:0], 64'h0000_0007_0000_0000);
    chk("t1_pay_hi_zero", 64'(|rsp_payload[255:64]), 64'd0);
    ack();
    chk("t1_idle_ready", 64'(cmd_ready), 64'd1);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // Channel busy for three polls, empty response payload
    busy_cfg = 3; rsp_l_cfg = 32'd4;
    clear_log();
    send(32'h0002_0000, 4'd0, '0);
    get_rsp("t2");
    chk("t2_stat_reads_pre", 64'(stat_pre), 64'd4);
    chk("t2_status", 64'(rsp_status), 64'd0);
    chk("t2_rsp_len", 64'(rsp_len), 64'd0);
    chk("t2_pay_zero", 64'(|rsp_payload), 64'd0);
    ack();
    busy_cfg = 0;

    // No completion: timeout
    irq_mode = 0; rsp_l_cfg = 32'd12;
    clear_log();
    send(32'h0003_0000, 4'd1, 256'h1234);
    get_rsp("t3");
    rsp_cyc = cyc;
    chk("t3_status", 64'(rsp_status), 64'd3);
    chk("t3_reads_after_db", 64'(rd_after_db), 64'd0);
    chk("t3_wait_cycles", 64'(rsp_cyc - db_cyc), 64'd51);
    ack();
    irq_mode = 1;

    // Bus error on the header write
    err_en = 1'b1; err_off = 32'h18;
    clear_log();
    send(32'h0004_0000, 4'd1, 256'h55);
    get_rsp("t4");
    chk("t4_status", 64'(rsp_status), 64'd2);
    chk("t4_db_cnt", 64'(db_cnt), 64'd0);
    chk("t4_wr_cnt", 64'(wr_cnt), 64'd2);
    chk("t4_rsp_hdr", 64'(rsp_hdr), 64'd0);
    ack();
    err_en = 1'b0;

    // Oversized response is clamped
    rsp_l_cfg = 32'd100;
    for (int k = 0; k < 8; k++) rsp_pay_cfg[k] = 32'h100 + 32'(k);
    clear_log();
    send(32'h0005_0000, 4'd0, '0);
    get_rsp("t5a");
    chk("t5a_status", 64'(rsp_status), 64'd0);
    chk("t5a_rsp_len", 64'(rsp_len), 64'd8);
    chk("t5a_pay_reads", 64'(pay_rd), 64'd8);
    chk("t5a_word7", 64'(rsp_payload[255:224]), 64'h107);
    ack();

    // Length below header size
    rsp_l_cfg = 32'd2;
    clear_log();
    send(32'h0006_0000, 4'd0, '0);
    get_rsp("t5b");
    chk("t5b_status", 64'(rsp_status), 64'd1);
    chk("t5b_rsp_len", 64'(rsp_len), 64'd0);
    chk("t5b_reads_after_db", 64'(rd_after_db), 64'd2);
    chk("t5b_rsp_hdr", 64'(rsp_hdr), 64'd0);
    ack();

    // Channel error flag still reads the response
    rsp_l_cfg = 32'd8; ch_err = 1'b1; rsp_hdr_cfg = 32'hABCD_0001;
    clear_log();
    send(32'h0007_0000, 4'd0, '0);
    get_rsp("t5c");
    chk("t5c_status", 64'(rsp_status), 64'd1);
    chk("t5c_rsp_len", 64'(rsp_len), 64'd1);
    chk("t5c_rsp_hdr", 64'(rsp_hdr), 64'hABCD_0001);
    chk("t5c_word0", 64'(rsp_payload[31:0]), 64'h100);
    ack();
    ch_err = 1'b0;

    // Completion in the doorbell-accept cycle
    irq_mode = 2; rsp_l_cfg = 32'd12;
    clear_log();
    send(32'h0008_0000, 4'd1, 256'h9);
    get_rsp("t6");
    chk("t6_status", 64'(rsp_status), 64'd0);
    chk("t6_rsp_len", 64'(rsp_len), 64'd2);
    ack();
    irq_mode = 1;

    // Reset during payload write
    clear_log();
    p = '0; for (int k = 0; k < 4; k++) p[32*k +: 32] = 32'hF0 + 32'(k);
    send(32'h0009_0000, 4'd4, p);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (bus.valid && bus.write && off == 32'h1C) found = 1'b1;
    end
    chk("t7_reach_wr_pay", 64'(found), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t7_reg_valid", 64'(bus.valid), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t7_cmd_ready", 64'(cmd_ready), 64'd1);
    rsp_l_cfg = 32'd8;
    clear_log();
    send(32'h000A_0000, 4'd1, 256'h3);
    get_rsp("t7");
    chk("t7_status", 64'(rsp_status), 64'd0);
    chk("t7_rsp_len", 64'(rsp_len), 64'd1);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
